// File: rtl/ad7643_pkg.sv
// ad7643_pkg: shared types and defaults for the AD7643 serial reader
package ad7643_pkg;
  localparam int NBITS_DEFAULT = 18;
  typedef enum logic [2:0] {IDLE, CNV, WAITB, SHIFT, DONE} state_e;
  typedef enum logic {PH_LOW, PH_HIGH} phase_e;
endpackage

// File: rtl/ad7643_tick_gen.sv
// ad7643_tick_gen: free-running period counter gated by enable, one-cycle tick at PERIOD-1
module ad7643_tick_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] period_i,
  output logic        tick_o
);
  logic [15:0] cnt_q, cnt_d, last;
  assign last = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
  // >= keeps the counter from running away when PERIOD shrinks mid-count
  always_comb begin
    tick_o = en_i && (cnt_q >= last);
    cnt_d  = (!en_i || tick_o) ? 16'd0 : cnt_q + 16'd1;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ad7643_serial_reader.sv
// ad7643_serial_reader: paced AD7643 conversions, serial readout and valid/ready result delivery
module ad7643_serial_reader
  import ad7643_pkg::*;
#(
  parameter int NBITS    = NBITS_DEFAULT,
  parameter int SCLK_DIV = 2,
  parameter int CNVST_W  = 4,
  parameter int BUSY_TO  = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [15:0]      PERIOD,
  input  logic             CLR_FLAGS,
  output logic             ADCNVST,
  output logic             ADCS,
  output logic             ADSCLK,
  input  logic             ADBUSY,
  input  logic             ADSDOUT,
  output logic [NBITS-1:0] SAMPLE,
  output logic             SAMPLE_VALID,
  input  logic             SAMPLE_READY,
  output logic             OVERRUN,
  output logic             DROP,
  output logic             TIMEOUT,
  output logic             ACTIVE
);
  localparam int BW = $clog2(NBITS + 1);
  state_e state_q, state_d;
  phase_e ph_q, ph_d;
  logic [15:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NBITS-1:0] sh_q, sh_d, sample_q, sample_d;
  logic seen_q, seen_d, valid_q, valid_d;
  logic ovr_q, ovr_d, drop_q, drop_d, to_q, to_d;
  logic busy_s1_q, busy_s2_q, sdo_q, tick, load, drop_evt, to_evt;

  ad7643_tick_gen u_tick (
    .clk_i(CLK), .rst_i(RST), .en_i(EN), .period_i(PERIOD), .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    seen_d   = seen_q;
    sample_d = sample_q;
    load     = 1'b0;
    drop_evt = 1'b0;
    to_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = tick ? CNV : IDLE;
        cnt_d   = '0;
      end
      CNV: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CNVST_W - 1)) begin
          state_d = WAITB;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end
      WAITB: begin
        cnt_d  = cnt_q + 16'd1;
        seen_d = seen_q | busy_s2_q;
        if (seen_q && !busy_s2_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          ph_d    = PH_LOW;
        end else if (cnt_q == 16'(BUSY_TO - 1)) begin
          state_d = IDLE;
          to_evt  = 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(SCLK_DIV - 1)) begin
          cnt_d = '0;
          ph_d  = (ph_q == PH_LOW) ? PH_HIGH : PH_LOW;
          // falling SCLK edge: capture the bit and count the pulse
          if (ph_q == PH_HIGH) begin
            sh_d    = {sh_q[NBITS-2:0], sdo_q};
            bit_d   = bit_q + BW'(1);
            state_d = (bit_q == BW'(NBITS - 1)) ? DONE : SHIFT;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        load     = !valid_q || SAMPLE_READY;
        drop_evt = !load;
        sample_d = load ? sh_q : sample_q;
      end
      default: state_d = IDLE;
    endcase
    valid_d = load ? 1'b1 : (valid_q && !SAMPLE_READY);
    ovr_d   = (tick && state_q != IDLE) || (ovr_q && !CLR_FLAGS);
    drop_d  = drop_evt || (drop_q && !CLR_FLAGS);
    to_d    = to_evt || (to_q && !CLR_FLAGS);
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      ph_q      <= PH_LOW;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      seen_q    <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      drop_q    <= 1'b0;
      to_q      <= 1'b0;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      seen_q    <= seen_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
      to_q      <= to_d;
      busy_s1_q <= ADBUSY;
      busy_s2_q <= busy_s1_q;
      sdo_q     <= ADSDOUT;
    end

  assign ADCNVST      = state_q != CNV;
  assign ADCS         = state_q == IDLE || state_q == DONE;
  assign ADSCLK       = state_q == SHIFT && ph_q == PH_HIGH;
  assign ACTIVE       = state_q != IDLE;
  assign SAMPLE       = sample_q;
  assign SAMPLE_VALID = valid_q;
  assign OVERRUN      = ovr_q;
  assign DROP         = drop_q;
  assign TIMEOUT      = to_q;
endmodule

// File: tb/tb_ad7643_serial_reader.sv
// tb_ad7643_serial_reader: directed scenarios against a behavioural AD7643 BUSY/SDOUT model
module tb_ad7643_serial_reader;
  logic clk = 0, rst, en, clr, busy, sdout, ready;
  logic [15:0] period;
  logic cnvst, cs, sclk, valid, ovr, drop, tout, active;
  logic [17:0] sample;
  logic [17:0] pat = 18'h2A5A5;
  logic stuck = 0;
  int checks = 0, passed = 0;

  ad7643_serial_reader dut (
    .CLK(clk), .RST(rst), .EN(en), .PERIOD(period), .CLR_FLAGS(clr),
    .ADCNVST(cnvst), .ADCS(cs), .ADSCLK(sclk), .ADBUSY(busy), .ADSDOUT(sdout),
    .SAMPLE(sample), .SAMPLE_VALID(valid), .SAMPLE_READY(ready),
    .OVERRUN(ovr), .DROP(drop), .TIMEOUT(tout), .ACTIVE(active)
  );

  always #4 clk = ~clk;

  // ADC model: BUSY high 2 cycles after CNVST falls for 40 cycles; next bit after each SCLK fall
  int nf = 0, bc = 0;
  logic sp = 0, cp = 1;
  initial begin
    busy = 0;
    sdout = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cp && !cnvst) bc = 1;
      else if (bc > 0 && bc < 43) bc++;
      else bc = 0;
      cp = cnvst;
      busy = !stuck && bc >= 3 && bc <= 42;
      if (cs) nf = 0;
      else if (sp && !sclk) nf++;
      sp = sclk;
      sdout = (nf < 18) ? pat[17-nf] : 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!valid && n < lim) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({cnvst, cs, sclk, valid, ovr, drop, tout, active} !== 8'b11000000)
      $display("FAIL reset_outputs got=%b want=11000000", {cnvst, cs, sclk, valid, ovr, drop, tout, active});
    else passed++;
    checks++;
    if (sample !== 18'h0) $display("FAIL reset_sample got=%h want=00000", sample);
    else passed++;
  endtask

  task automatic test_basic;
    int n, w;
    period = 200; ready = 1; pat = 18'h2A5A5; en = 1;
    wait_valid(400, n);
    checks++;
    if (sample !== 18'h2A5A5 || n >= 400) $display("FAIL basic_word1 got=%h want=2a5a5", sample);
    else passed++;
    cyc(1);
    checks++;
    if (valid !== 1'b0) $display("FAIL basic_pulse got=%b want=0", valid);
    else passed++;
    n = 0;
    while (cnvst && n < 300) begin cyc(1); n++; end
    w = 0;
    while (!cnvst && w < 20) begin cyc(1); w++; end
    checks++;
    if (w !== 4) $display("FAIL cnvst_width got=%0d want=4", w);
    else passed++;
    w = 0; n = 0;
    while (!cs && n < 300) begin
      if (sclk) w++;
      cyc(1); n++;
    end
    checks++;
    if (w !== 36) $display("FAIL sclk_high_cycles got=%0d want=36", w);
    else passed++;
    wait_valid(400, n);
    checks++;
    if (sample !== 18'h2A5A5) $display("FAIL basic_word2 got=%h want=2a5a5", sample);
    else passed++;
    cyc(1);
    wait_valid(400, n);
    checks++;
    if (n + 1 !== 200) $display("FAIL basic_gap got=%0d want=200", n + 1);
    else passed++;
    checks++;
    if ({ovr, drop, tout} !== 3'b000) $display("FAIL basic_flags got=%b want=000", {ovr, drop, tout});
    else passed++;
    en = 0;
    cyc(5);
  endtask

  task automatic test_overrun;
    int n;
    period = 60; en = 1;
    wait_valid(400, n);
    cyc(1);
    wait_valid(400, n);
    checks++;
    if (n + 1 !== 120) $display("FAIL overrun_gap got=%0d want=120", n + 1);
    else passed++;
    checks++;
    if (ovr !== 1'b1 || sample !== 18'h2A5A5) $display("FAIL overrun_flag got=%b/%h want=1/2a5a5", ovr, sample);
    else passed++;
    en = 0;
    n = 0;
    while (active && n < 200) begin cyc(1); n++; end
    clr = 1; cyc(1); clr = 0;
    checks++;
    if (ovr !== 1'b0) $display("FAIL overrun_clear got=%b want=0", ovr);
    else passed++;
  endtask

  task automatic test_drop;
    int n;
    period = 200; ready = 0; pat = 18'h3C0F1; en = 1;
    wait_valid(400, n);
    checks++;
    if (sample !== 18'h3C0F1) $display("FAIL drop_first got=%h want=3c0f1", sample);
    else passed++;
    pat = 18'h15555;
    n = 0;
    while (!drop && n < 300) begin cyc(1); n++; end
    en = 0;
    checks++;
    if ({drop, valid} !== 2'b11 || sample !== 18'h3C0F1)
      $display("FAIL drop_hold got=%b%b/%h want=11/3c0f1", drop, valid, sample);
    else passed++;
    ready = 1;
    cyc(1);
    checks++;
    if (valid !== 1'b0) $display("FAIL drop_accept got=%b want=0", valid);
    else passed++;
    clr = 1; cyc(1); clr = 0;
    checks++;
    if (drop !== 1'b0) $display("FAIL drop_clear got=%b want=0", drop);
    else passed++;
  endtask

  task automatic test_timeout;
    int n;
    logic sv;
    stuck = 1; period = 400; ready = 1; pat = 18'h2A5A5; en = 1;
    n = 0;
    while (cnvst && n < 500) begin cyc(1); n++; end
    n = 0; sv = 0;
    while (!cs && n < 400) begin
      sv |= valid;
      cyc(1); n++;
    end
    en = 0;
    checks++;
    if (n !== 259) $display("FAIL timeout_len got=%0d want=259", n);
    else passed++;
    checks++;
    if ({tout, cs, sv, valid} !== 4'b1100) $display("FAIL timeout_state got=%b want=1100", {tout, cs, sv, valid});
    else passed++;
    clr = 1; cyc(1); clr = 0;
    checks++;
    if (tout !== 1'b0) $display("FAIL timeout_clear got=%b want=0", tout);
    else passed++;
    stuck = 0;
    cyc(5);
  endtask

  task automatic test_reset_mid;
    int n;
    period = 200; en = 1;
    n = 0;
    while (!(nf == 8 && sclk) && n < 400) begin cyc(1); n++; end
    #1 rst = 1;
    #1;
    checks++;
    if ({cs, sclk, valid, active, cnvst} !== 5'b10001 || sample !== 18'h0)
      $display("FAIL reset_mid got=%b/%h want=10001/00000", {cs, sclk, valid, active, cnvst}, sample);
    else passed++;
    @(posedge clk);
    #1 rst = 0;
    wait_valid(400, n);
    checks++;
    if (sample !== 18'h2A5A5 || n >= 400) $display("FAIL reset_recover got=%h want=2a5a5", sample);
    else passed++;
  endtask

  task automatic test_en_drop;
    int n, falls;
    logic pc;
    pat = 18'h0F0F3;
    n = 0;
    while (!sclk && n < 400) begin cyc(1); n++; end
    en = 0;
    wait_valid(200, n);
    checks++;
    if (sample !== 18'h0F0F3 || n >= 200) $display("FAIL en_drop_word got=%h want=0f0f3", sample);
    else passed++;
    falls = 0; pc = cnvst;
    repeat (500) begin
      cyc(1);
      if (pc && !cnvst) falls++;
      pc = cnvst;
    end
    checks++;
    if (falls !== 0 || active !== 1'b0) $display("FAIL en_drop_quiet got=%0d/%b want=0/0", falls, active);
    else passed++;
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; ready = 1; period = 200;
    cyc(3);
    test_reset;
    rst = 0;
    cyc(2);
    test_basic;
    test_overrun;
    test_drop;
    test_timeout;
    test_reset_mid;
    test_en_drop;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
